// File: rtl/watch_alarm_bank.sv
// Purpose: bank of N BCD HH:MM alarms with priority arbitration, pending queue, snooze and auto-silence.
// Latency: min_tick match -> alarm_sound next cycle; button edges and writes take effect on the next edge.
// Backpressure: none; overlapping matches wait in the pending vector and buttons act once per press.
module watch_alarm_bank #(
    parameter int N_ALARMS     = 4,
    parameter int SNOOZE_MIN   = 5,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_SECONDS = 60,
    parameter int IDXW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
    parameter int SCW          = ($clog2(MAX_SNOOZE + 1) > 2) ? $clog2(MAX_SNOOZE + 1) : 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sec_tick,
    input  logic                min_tick,
    input  logic [1:0]          tens_hours_in,
    input  logic [3:0]          units_hours_in,
    input  logic [2:0]          tens_minutes_in,
    input  logic [3:0]          units_minutes_in,
    input  logic                wr_en,
    input  logic [IDXW-1:0]     wr_idx,
    input  logic                wr_enable,
    input  logic [1:0]          wr_tens_hours,
    input  logic [3:0]          wr_units_hours,
    input  logic [2:0]          wr_tens_minutes,
    input  logic [3:0]          wr_units_minutes,
    input  logic                snooze,
    input  logic                dismiss,
    output logic                alarm_sound,
    output logic [IDXW-1:0]     ring_idx,
    output logic [N_ALARMS-1:0] pending,
    output logic [SCW-1:0]      snooze_cnt,
    output logic                wr_err
);

    typedef struct packed {
        logic       armed;
        logic [1:0] th;
        logic [3:0] uh;
        logic [2:0] tm;
        logic [3:0] um;
    } slot_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RINGING,
        S_SNOOZED
    } state_t;

    localparam logic [IDXW:0]  IDX_LIM   = (IDXW + 1)'(N_ALARMS);
    localparam logic [7:0]     RING_LAST = 8'(RING_SECONDS - 1);
    localparam logic [5:0]     SNZ_LOAD  = 6'(SNOOZE_MIN);
    localparam logic [SCW-1:0] SNZ_MAX   = SCW'(MAX_SNOOZE);

    slot_t               slots [N_ALARMS];
    state_t              state, state_n;
    logic [IDXW-1:0]     ring_idx_n;
    logic [N_ALARMS-1:0] pending_n;
    logic [SCW-1:0]      snooze_cnt_n;
    logic [7:0]          ring_timer, ring_timer_n;
    logic [5:0]          min_left, min_left_n;
    logic                snooze_q, dismiss_q;
    logic                snooze_p, dismiss_p;
    logic                wr_legal;
    logic [N_ALARMS-1:0] match;
    logic [N_ALARMS-1:0] req;
    logic [N_ALARMS-1:0] ring_oh;
    logic [N_ALARMS-1:0] low_oh;
    logic [IDXW-1:0]     low_idx;
    slot_t               wr_slot;

    assign snooze_p  = snooze & ~snooze_q;
    assign dismiss_p = dismiss & ~dismiss_q;

    // Hours 20..23 need the units digit capped at 3; tens_minutes is 3 bits so 6 and 7 must be rejected.
    assign wr_legal = ({1'b0, wr_idx} < IDX_LIM)
                    && ((wr_tens_hours < 2'd2) ? (wr_units_hours <= 4'd9)
                                               : ((wr_tens_hours == 2'd2) && (wr_units_hours <= 4'd3)))
                    && (wr_tens_minutes <= 3'd5)
                    && (wr_units_minutes <= 4'd9);

    assign wr_slot = '{armed: wr_enable, th: wr_tens_hours, uh: wr_units_hours,
                       tm: wr_tens_minutes, um: wr_units_minutes};

    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            match[i] = min_tick && slots[i].armed
                    && (slots[i].th == tens_hours_in)   && (slots[i].uh == units_hours_in)
                    && (slots[i].tm == tens_minutes_in) && (slots[i].um == units_minutes_in);
        end
    end

    assign req     = match | pending;
    assign ring_oh = N_ALARMS'(1) << ring_idx;
    assign low_oh  = N_ALARMS'(1) << low_idx;

    always_comb begin
        low_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (req[i]) low_idx = IDXW'(i);
        end
    end

    always_comb begin
        state_n      = state;
        ring_idx_n   = ring_idx;
        pending_n    = pending;
        snooze_cnt_n = snooze_cnt;
        ring_timer_n = ring_timer;
        min_left_n   = min_left;
        case (state)
            S_IDLE: begin
                snooze_cnt_n = '0;
                ring_timer_n = '0;
                pending_n    = req & ~low_oh;
                if (|req) begin
                    state_n    = S_RINGING;
                    ring_idx_n = low_idx;
                end
            end
            S_RINGING: begin
                pending_n = pending | (match & ~ring_oh);
                if (dismiss_p) begin
                    state_n = S_IDLE;
                end else if (snooze_p) begin
                    if (snooze_cnt < SNZ_MAX) begin
                        state_n      = S_SNOOZED;
                        snooze_cnt_n = snooze_cnt + 1'b1;
                        min_left_n   = SNZ_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (sec_tick) begin
                    if (ring_timer == RING_LAST) state_n = S_IDLE;
                    else                         ring_timer_n = ring_timer + 8'd1;
                end
            end
            S_SNOOZED: begin
                pending_n = pending | (match & ~ring_oh);
                if (dismiss_p) begin
                    state_n = S_IDLE;
                end else if (min_tick) begin
                    if (min_left == 6'd1) begin
                        state_n      = S_RINGING;
                        ring_timer_n = '0;
                    end else begin
                        min_left_n = min_left - 6'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ring_idx    <= '0;
            pending     <= '0;
            snooze_cnt  <= '0;
            ring_timer  <= '0;
            min_left    <= '0;
            alarm_sound <= 1'b0;
            wr_err      <= 1'b0;
            snooze_q    <= 1'b0;
            dismiss_q   <= 1'b0;
            for (int i = 0; i < N_ALARMS; i++) slots[i] <= '0;
        end else begin
            state       <= state_n;
            ring_idx    <= ring_idx_n;
            pending     <= pending_n;
            snooze_cnt  <= snooze_cnt_n;
            ring_timer  <= ring_timer_n;
            min_left    <= min_left_n;
            alarm_sound <= (state_n == S_RINGING);
            wr_err      <= wr_en & ~wr_legal;
            snooze_q    <= snooze;
            dismiss_q   <= dismiss;
            // Match above used the old slot contents, so a same-cycle write only affects later ticks.
            if (wr_en && wr_legal) slots[wr_idx] <= wr_slot;
        end
    end

endmodule

// File: tb/tb_watch_alarm_bank.sv
// Self-checking bench: directed scenarios plus random traffic against a minute-of-day reference model.
module tb_watch_alarm_bank;
    localparam int N  = 4;
    localparam int SM = 5;
    localparam int MS = 3;
    localparam int RS = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1, sec_tick = 1'b0, min_tick = 1'b0;
    logic [1:0] th_in = '0;
    logic [3:0] uh_in = '0;
    logic [2:0] tm_in = '0;
    logic [3:0] um_in = '0;
    logic       wr_en = 1'b0, wr_enable = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [1:0] wr_th = '0;
    logic [3:0] wr_uh = '0;
    logic [2:0] wr_tm = '0;
    logic [3:0] wr_um = '0;
    logic       snooze = 1'b0, dismiss = 1'b0;
    logic       alarm_sound, wr_err;
    logic [1:0] ring_idx;
    logic [3:0] pending;
    logic [1:0] snooze_cnt;

    always #5 clk = ~clk;

    watch_alarm_bank #(.N_ALARMS(N), .SNOOZE_MIN(SM), .MAX_SNOOZE(MS), .RING_SECONDS(RS)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .min_tick(min_tick),
        .tens_hours_in(th_in), .units_hours_in(uh_in),
        .tens_minutes_in(tm_in), .units_minutes_in(um_in),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_enable(wr_enable),
        .wr_tens_hours(wr_th), .wr_units_hours(wr_uh),
        .wr_tens_minutes(wr_tm), .wr_units_minutes(wr_um),
        .snooze(snooze), .dismiss(dismiss),
        .alarm_sound(alarm_sound), .ring_idx(ring_idx), .pending(pending),
        .snooze_cnt(snooze_cnt), .wr_err(wr_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 idle, 1 ringing, 2 snoozed; slot times as minutes of day.
    int cur_min = 0;
    int m_mode = 0, m_idx = 0, m_pend = 0, m_scnt = 0, m_timer = 0, m_left = 0, e_err = 0;
    bit m_sq = 0, m_dq = 0;
    bit m_armed [N];
    int m_time  [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int lowest(input int v);
        for (int i = 0; i < N; i++) if (((v >> i) & 1) == 1) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_pend = 0; m_scnt = 0; m_timer = 0; m_left = 0;
        m_sq = 0; m_dq = 0; e_err = 0;
        for (int i = 0; i < N; i++) begin m_armed[i] = 0; m_time[i] = 0; end
    endtask

    task automatic model_step();
        int match, req, hrs, mins;
        bit sp, dp, legal;
        if (rst) begin model_reset(); return; end
        match = 0;
        for (int i = 0; i < N; i++)
            if (min_tick && m_armed[i] && m_time[i] == cur_min) match |= (1 << i);
        sp = snooze && !m_sq;
        dp = dismiss && !m_dq;
        m_sq = snooze;
        m_dq = dismiss;
        case (m_mode)
            0: begin
                m_scnt = 0; m_timer = 0;
                req = match | m_pend;
                if (req != 0) begin
                    m_idx = lowest(req);
                    m_pend = req & ~(1 << m_idx);
                    m_mode = 1;
                end
            end
            1: begin
                m_pend |= match & ~(1 << m_idx);
                if (dp) m_mode = 0;
                else if (sp) begin
                    if (m_scnt < MS) begin m_scnt++; m_left = SM; m_mode = 2; end
                    else m_mode = 0;
                end else if (sec_tick) begin
                    m_timer++;
                    if (m_timer == RS) m_mode = 0;
                end
            end
            default: begin
                m_pend |= match & ~(1 << m_idx);
                if (dp) m_mode = 0;
                else if (min_tick) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 1; m_timer = 0; end
                end
            end
        endcase
        hrs   = int'(wr_th) * 10 + int'(wr_uh);
        mins  = int'(wr_tm) * 10 + int'(wr_um);
        legal = (wr_uh <= 9) && (wr_um <= 9) && (hrs < 24) && (mins < 60) && (int'(wr_idx) < N);
        e_err = (wr_en && !legal) ? 1 : 0;
        if (wr_en && legal) begin
            m_armed[wr_idx] = wr_enable;
            m_time[wr_idx]  = hrs * 60 + mins;
        end
    endtask

    task automatic drive_time();
        int h, m;
        h = cur_min / 60;
        m = cur_min % 60;
        th_in = 2'(h / 10); uh_in = 4'(h % 10);
        tm_in = 3'(m / 10); um_in = 4'(m % 10);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("alarm_sound", alarm_sound, (m_mode == 1) ? 1 : 0);
        check("ring_idx", ring_idx, m_idx);
        check("pending", pending, m_pend);
        check("snooze_cnt", snooze_cnt, m_scnt);
        check("wr_err", wr_err, e_err);
        sec_tick = 0; min_tick = 0; wr_en = 0;
    endtask

    task automatic set_wr(input int idx, input bit en, input int a, input int b, input int c, input int d);
        wr_en = 1; wr_idx = 2'(idx); wr_enable = en;
        wr_th = 2'(a); wr_uh = 4'(b); wr_tm = 3'(c); wr_um = 4'(d);
    endtask

    task automatic write_slot(input int idx, input bit en, input int a, input int b, input int c, input int d);
        set_wr(idx, en, a, b, c, d);
        cyc();
    endtask

    task automatic minute(input int m);
        cur_min = m; drive_time(); min_tick = 1; cyc();
    endtask

    task automatic press_dismiss();
        dismiss = 1; cyc(); dismiss = 0; cyc();
    endtask

    task automatic press_snooze();
        snooze = 1; cyc(); snooze = 0; cyc();
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) begin sec_tick = 1; cyc(); cyc(); end
    endtask

    initial begin
        model_reset();
        drive_time();
        cyc(); cyc();
        rst = 0;
        check("reset_sound", alarm_sound, 0);
        check("reset_pending", pending, 0);
        cyc();

        // Basic match and dismiss.
        write_slot(0, 1, 0, 2, 0, 5);
        cur_min = 124; drive_time(); cyc();
        minute(125);
        check("basic_ring", alarm_sound, 1);
        check("basic_idx", ring_idx, 0);
        dismiss = 1; cyc();
        check("basic_dismiss", alarm_sound, 0);
        dismiss = 0; cyc();

        // Arbitration between slots 1 and 3.
        write_slot(1, 1, 0, 7, 3, 0);
        write_slot(3, 1, 0, 7, 3, 0);
        minute(450);
        check("arb_idx", ring_idx, 1);
        check("arb_pending", pending, 4'b1000);
        dismiss = 1; cyc();
        check("arb_gap", alarm_sound, 0);
        dismiss = 0; cyc();
        check("arb_next_idx", ring_idx, 3);
        check("arb_next_sound", alarm_sound, 1);
        check("arb_next_pending", pending, 0);
        press_dismiss();

        // Snooze limit.
        write_slot(3, 0, 0, 7, 3, 0);
        minute(450);
        for (int k = 1; k <= MS; k++) begin
            press_snooze();
            check("snooze_quiet", alarm_sound, 0);
            for (int j = 0; j < SM; j++) minute(cur_min + 1);
            check("snooze_rering", alarm_sound, 1);
        end
        check("snooze_cnt_max", snooze_cnt, MS);
        snooze = 1; cyc();
        check("snooze_over_limit", alarm_sound, 0);
        snooze = 0; cyc(); cyc();

        // Held snooze counts once, then timeout.
        cur_min = 449; drive_time(); cyc();
        minute(450);
        snooze = 1; cyc(); cyc(); cyc();
        check("held_snooze_cnt", snooze_cnt, 1);
        snooze = 0;
        for (int j = 0; j < SM; j++) minute(cur_min + 1);
        secs(RS - 1);
        check("timeout_before", alarm_sound, 1);
        secs(1);
        check("timeout_after", alarm_sound, 0);

        // Snooze and dismiss together.
        cur_min = 449; drive_time(); cyc();
        minute(450);
        snooze = 1; dismiss = 1; cyc();
        check("both_sound", alarm_sound, 0);
        check("both_cnt", snooze_cnt, 0);
        snooze = 0; dismiss = 0; cyc(); cyc();

        // Illegal writes leave the slot unchanged.
        write_slot(2, 1, 1, 0, 1, 0);
        write_slot(2, 1, 2, 4, 0, 0);
        check("err_24h", wr_err, 1);
        write_slot(2, 1, 1, 2, 6, 0);
        check("err_60m", wr_err, 1);
        write_slot(2, 1, 0, 10, 0, 0);
        check("err_digit", wr_err, 1);
        cur_min = 609; drive_time(); cyc();
        minute(610);
        check("unchanged_ring", ring_idx, 2);
        press_dismiss();

        // Write in the same cycle as a matching tick uses the old value.
        set_wr(2, 1, 1, 1, 1, 1);
        minute(610);
        check("same_cycle_old", alarm_sound, 1);
        press_dismiss();
        minute(671);
        check("same_cycle_new", alarm_sound, 1);
        press_dismiss();

        // Reset mid-ring with pending.
        write_slot(3, 1, 0, 7, 3, 0);
        cur_min = 449; drive_time(); cyc();
        minute(450);
        check("prereset_pending", pending, 4'b1000);
        rst = 1; cyc(); rst = 0;
        check("rst_sound", alarm_sound, 0);
        check("rst_idx", ring_idx, 0);
        check("rst_pending", pending, 0);
        check("rst_cnt", snooze_cnt, 0);
        minute(450);
        check("rst_no_ring", alarm_sound, 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            sec_tick = ($urandom % 4) == 0;
            if (($urandom % 16) == 0) begin
                min_tick = 1;
                if ($urandom % 2) cur_min = (cur_min + 1) % 1440;
                else cur_min = m_time[$urandom % N];
            end
            if (($urandom % 25) == 0) begin
                if (($urandom % 4) == 0)
                    set_wr($urandom % 4, 1'($urandom), $urandom % 4, $urandom % 16,
                           $urandom % 8, $urandom % 16);
                else begin
                    int t;
                    t = (cur_min + $urandom % 4) % 1440;
                    set_wr($urandom % 4, 1'($urandom), (t / 60) / 10, (t / 60) % 10,
                           (t % 60) / 10, (t % 60) % 10);
                end
            end
            snooze  = ($urandom % 8) == 0;
            dismiss = ($urandom % 20) == 0;
            rst     = ($urandom % 1500) == 0;
            drive_time();
            cyc();
            rst = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
